// File: rtl/dmem_lsu.sv
// RV32I data-memory load/store responder: byte-lane aligned word RAM, one request in flight.
// Define DMEM_MISALIGN_ERR_EN to flag misaligned half/word accesses as errors instead of aligning them.
module dmem_lsu #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned RD_LAT      = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [1:0] LAT_INIT = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  typedef enum logic [1:0] {S_IDLE, S_LAT, S_WAIT, S_RESP} state_t;

  state_t        r_state, w_next;
  logic [1:0]    r_cnt;
  logic          r_we, r_err;
  logic [2:0]    r_f3;
  logic [1:0]    r_off;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          w_accept, w_legal, w_misalign, w_err;
  logic [AW-1:0] w_idx;
  logic [3:0]    w_be;
  logic [31:0]   w_wrep, w_word, w_ldata;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic          w_unused_addr;

  assign w_accept      = req_valid && (r_state == S_IDLE);
  assign w_idx         = req_addr[AW+1:2];
  assign w_unused_addr = ^req_addr[31:AW+2];

  always_comb begin
    w_legal = 1'b0;
    if (req_we) begin
      w_legal = (req_funct3 <= 3'd2);
    end else begin
      case (req_funct3)
        3'd0, 3'd1, 3'd2, 3'd4, 3'd5: w_legal = 1'b1;
        default:                      w_legal = 1'b0;
      endcase
    end
  end

`ifdef DMEM_MISALIGN_ERR_EN
  assign w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  // Half lanes key off addr[1] only and words ignore addr[1:0], which is the forced alignment.
  assign w_misalign = 1'b0;
`endif

  assign w_err = !w_legal || w_misalign;

  always_comb begin
    w_be   = 4'b1111;
    w_wrep = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        w_be   = 4'b0001 << req_addr[1:0];
        w_wrep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_be   = req_addr[1] ? 4'b1100 : 4'b0011;
        w_wrep = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_accept && req_we && !w_err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wrep[8*i +: 8];
      end
    end
  end

  assign w_word = r_mem[r_idx];
  assign w_byte = w_word[8*r_off +: 8];
  assign w_half = r_off[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_ldata = '0;
    case (r_f3)
      3'd0:    w_ldata = {{24{w_byte[7]}}, w_byte};
      3'd1:    w_ldata = {{16{w_half[15]}}, w_half};
      3'd2:    w_ldata = w_word;
      3'd4:    w_ldata = {24'd0, w_byte};
      3'd5:    w_ldata = {16'd0, w_half};
      default: w_ldata = '0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = (req_we || RD_LAT <= 1) ? S_WAIT : S_LAT;
      S_LAT:  if (r_cnt == 2'd0) w_next = S_WAIT;
      S_WAIT: w_next = S_RESP;
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_we      <= 1'b0;
      r_err     <= 1'b0;
      r_f3      <= '0;
      r_off     <= '0;
      r_idx     <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt <= LAT_INIT;
        r_we  <= req_we;
        r_err <= w_err;
        r_f3  <= req_funct3;
        r_off <= req_addr[1:0];
        r_idx <= w_idx;
      end else if (r_state == S_LAT && r_cnt != 2'd0) begin
        r_cnt <= r_cnt - 2'd1;
      end
      // RAM is read in WAIT so the registered response appears on entry to RESP.
      if (r_state == S_WAIT) begin
        rsp_err   <= r_err;
        rsp_rdata <= (r_we || r_err) ? '0 : w_ldata;
      end
    end
  end

  assign rsp_valid = (r_state == S_RESP);
  assign req_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: byte-array memory model, per-cycle compare process, directed vectors.
module tb_dmem_lsu;
  localparam int unsigned LAT = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  dmem_lsu #(.DEPTH_WORDS(256), .RD_LAT(LAT)) u_dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0]  bm [0:1023];
  bit          pend = 1'b0;
  int          acc = 0;
  int          lat = 0;
  logic [31:0] e_data = '0;
  logic        e_err = 1'b0;
  logic [31:0] last_d = '0;
  logic        last_e = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference memory as little-endian bytes; extension by arithmetic on the assembled value.
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, output logic [31:0] d, output logic e);
    int unsigned n, a;
    logic [31:0] v;
    bit legal;
    d = '0;
    e = 1'b0;
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    n = 1 << f3[1:0];
    a = 32'(addr[9:0]);
    if (!legal) begin
      e = 1'b1;
      return;
    end
`ifdef DMEM_MISALIGN_ERR_EN
    if (a % n != 0) begin
      e = 1'b1;
      return;
    end
`else
    a = a - a % n;
`endif
    if (we) begin
      for (int unsigned k = 0; k < n; k++) bm[a+k] = wd[8*k +: 8];
    end else begin
      v = '0;
      for (int unsigned k = 0; k < n; k++) v[8*k +: 8] = bm[a+k];
      if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
      d = v;
    end
  endfunction

  always @(negedge clk) begin
    bit inf, vexp;
    inf  = pend && cyc >= acc && cyc <= acc + lat;
    vexp = pend && cyc == acc + lat;
    check("busy", {31'd0, busy}, {31'd0, inf});
    check("req_ready", {31'd0, req_ready}, {31'd0, !inf});
    check("rsp_valid", {31'd0, rsp_valid}, {31'd0, vexp});
    if (vexp) begin
      check("rsp_rdata", rsp_rdata, e_data);
      check("rsp_err", {31'd0, rsp_err}, {31'd0, e_err});
      last_d = e_data;
      last_e = e_err;
    end else begin
      check("rdata_hold", rsp_rdata, last_d);
      check("err_hold", {31'd0, rsp_err}, {31'd0, last_e});
    end
  end

  task automatic wait_ready();
    int w;
    w = 0;
    while (!req_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    if (!req_ready) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_req(input string name, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_d, input logic exp_e);
    logic [31:0] md;
    logic me;
    wait_ready();
    model(we, f3, addr, wd, md, me);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk); #1;
    e_data = md; e_err = me;
    lat = we ? 1 : int'(LAT);
    acc = cyc;
    pend = 1'b1;
    // A conflicting store held on the bus while busy must be ignored.
    req_we = 1'b1; req_funct3 = 3'd2; req_wdata = ~wd;
    repeat (lat) @(posedge clk);
    #1;
    req_valid = 1'b0;
    check(name, rsp_rdata, exp_d);
    check({name, "_err"}, {31'd0, rsp_err}, {31'd0, exp_e});
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    do_req("sw_10",   1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    do_req("lw_10",   0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    do_req("sb_13",   1, 3'd0, 32'h13, 32'h80, 32'h0, 0);
    do_req("lb_13",   0, 3'd0, 32'h13, 32'h0, 32'hFFFFFF80, 0);
    do_req("lbu_13",  0, 3'd4, 32'h13, 32'h0, 32'h00000080, 0);
    do_req("lw_sb",   0, 3'd2, 32'h10, 32'h0, 32'h80ADBEEF, 0);
    do_req("sw_rst",  1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    do_req("sh_12",   1, 3'd1, 32'h12, 32'h8234, 32'h0, 0);
    do_req("lh_12",   0, 3'd1, 32'h12, 32'h0, 32'hFFFF8234, 0);
    do_req("lhu_12",  0, 3'd5, 32'h12, 32'h0, 32'h00008234, 0);
    do_req("lw_sh",   0, 3'd2, 32'h10, 32'h0, 32'h8234BEEF, 0);
    do_req("st_ill",  1, 3'd3, 32'h10, 32'h0, 32'h0, 1);
    do_req("lw_ill",  0, 3'd2, 32'h10, 32'h0, 32'h8234BEEF, 0);
`ifdef DMEM_MISALIGN_ERR_EN
    do_req("lw_11",   0, 3'd2, 32'h11, 32'h0, 32'h0, 1);
`else
    do_req("lw_11",   0, 3'd2, 32'h11, 32'h0, 32'h8234BEEF, 0);
`endif
    do_req("ld_ill",  0, 3'd6, 32'h10, 32'h0, 32'h0, 1);
    do_req("lb_10",   0, 3'd0, 32'h10, 32'h0, 32'hFFFFFFEF, 0);
    do_req("lh_10",   0, 3'd1, 32'h10, 32'h0, 32'hFFFFBEEF, 0);
    do_req("lhu_10",  0, 3'd5, 32'h10, 32'h0, 32'h0000BEEF, 0);
    do_req("lw_alias",0, 3'd2, 32'hFFFFF010, 32'h0, 32'h8234BEEF, 0);
    do_req("sb_11",   1, 3'd0, 32'h11, 32'hFFFFFF11, 32'h0, 0);
    do_req("lw_sb11", 0, 3'd2, 32'h10, 32'h0, 32'h823411EF, 0);
    do_req("sw_3fc",  1, 3'd2, 32'h3FC, 32'h12345678, 32'h0, 0);
    do_req("lbu_3ff", 0, 3'd4, 32'h3FF, 32'h0, 32'h00000012, 0);

    // Reset one cycle after a load is accepted: the response must be dropped.
    wait_ready();
    req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    e_data = 32'h823411EF; e_err = 1'b0;
    lat = int'(LAT); acc = cyc; pend = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    pend = 1'b0; last_d = '0; last_e = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    do_req("lw_after_rst", 0, 3'd2, 32'h10, 32'h0, 32'h823411EF, 0);
    do_req("lw_3fc", 0, 3'd2, 32'h3FC, 32'h0, 32'h12345678, 0);

    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
